// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared definitions for the memory-access unit: MIPS
//               load/store opcodes, access-size codes, FSM state encodings
//               and small decode helpers.
// Contents    : c_op_*      6-bit load/store opcodes
//               c_size_*    access size held in op_code[1:0]
//               c_st_*      FSM state encodings
//               f_byte_enable, f_misaligned
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    // Load/store opcodes
    localparam logic [5:0] c_op_lb  = 6'b100000;
    localparam logic [5:0] c_op_lh  = 6'b100001;
    localparam logic [5:0] c_op_lw  = 6'b100011;
    localparam logic [5:0] c_op_lbu = 6'b100100;
    localparam logic [5:0] c_op_lhu = 6'b100101;
    localparam logic [5:0] c_op_sb  = 6'b101000;
    localparam logic [5:0] c_op_sh  = 6'b101001;
    localparam logic [5:0] c_op_sw  = 6'b101011;

    // Access size, taken from op_code[1:0]
    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_rsvd = 2'b10;
    localparam logic [1:0] c_size_word = 2'b11;

    // FSM states
    localparam logic [1:0] c_st_idle    = 2'b00;
    localparam logic [1:0] c_st_read    = 2'b01;
    localparam logic [1:0] c_st_capture = 2'b10;

    // Little-endian byte-lane write enables for an aligned access.
    function automatic logic [3:0] f_byte_enable(input logic [1:0] size,
                                                 input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            c_size_byte: be = 4'b0001 << addr_lo;
            c_size_half: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            c_size_word: be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Reserved size or an address not aligned to the access size.
    function automatic logic f_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
        return (size == c_size_rsvd)
            || ((size == c_size_half) && addr_lo[0])
            || ((size == c_size_word) && (addr_lo != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_load_extend
// Description : Combinational load-data extractor. Selects the byte or half
//               lane addressed by addr[1:0] from a memory word and sign- or
//               zero-extends it to the full datapath width.
// Ports       : i_rdata    NB  word returned by memory
//               i_addr_lo  2   byte offset within the word
//               i_size     2   access size code
//               i_unsigned 1   1 = zero-extend, 0 = sign-extend
//               o_data     NB  extended result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic [NB-1:0] i_rdata,
    input  logic [1:0]    i_addr_lo,
    input  logic [1:0]    i_size,
    input  logic          i_unsigned,
    output logic [NB-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_fill;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        w_fill = 1'b0;
        case (i_size)
            c_size_byte: begin
                w_fill = w_byte[7] & ~i_unsigned;
                o_data = {{(NB-8){w_fill}}, w_byte};
            end
            c_size_half: begin
                w_fill = w_half[15] & ~i_unsigned;
                o_data = {{(NB-16){w_fill}}, w_half};
            end
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory stage. Turns an execute-stage byte address and store
//               operand into registered strobes for a synchronous
//               single-port data memory, and returns extended load data.
//               Stores complete in one cycle; loads take three
//               (IDLE -> READ -> CAPTURE -> IDLE).
// Ports       : i_clk, i_reset (async, active-low)
//               i_valid/o_ready/o_stall     pipeline handshake
//               i_mem_read, i_mem_write, i_op_code, i_alu_result,
//               i_store_data                request
//               o_mem_addr, o_mem_we, o_mem_re, o_mem_wdata, i_mem_rdata
//                                           memory interface
//               o_load_data, o_load_valid   load result
//               o_fault                     misaligned/unsupported pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int NB        = 32,
    parameter int NB_OPCODE = 6,
    parameter int NB_ADDR   = 10
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [NB_OPCODE-1:0] i_op_code,
    input  logic [NB-1:0]        i_alu_result,
    input  logic [NB-1:0]        i_store_data,
    output logic [NB_ADDR-1:0]   o_mem_addr,
    output logic [3:0]           o_mem_we,
    output logic                 o_mem_re,
    output logic [NB-1:0]        o_mem_wdata,
    input  logic [NB-1:0]        i_mem_rdata,
    output logic [NB-1:0]        o_load_data,
    output logic                 o_load_valid,
    output logic                 o_fault,
    output logic                 o_stall
);

    logic [1:0]         r_state;
    logic [NB_ADDR-1:0] r_mem_addr;
    logic [3:0]         r_mem_we;
    logic               r_mem_re;
    logic [NB-1:0]      r_mem_wdata;
    logic [NB-1:0]      r_load_data;
    logic               r_load_valid;
    logic               r_fault;
    // Load request fields held from accept until CAPTURE completes
    logic [1:0]         r_addr_lo;
    logic [1:0]         r_size;
    logic               r_unsigned;

    logic [1:0]         w_size;
    logic [1:0]         w_addr_lo;
    logic               w_fault;
    logic               w_accept;
    logic               w_go_store;
    logic               w_go_load;
    logic [NB-1:0]      w_wdata;
    logic [NB-1:0]      w_ext;
    logic               w_unused_bits;

    assign w_size    = i_op_code[1:0];
    assign w_addr_lo = i_alu_result[1:0];
    assign w_fault   = f_misaligned(w_size, w_addr_lo);

    assign o_ready   = (r_state == c_st_idle);
    assign o_stall   = i_valid & ~o_ready;
    assign w_accept  = i_valid & o_ready & (i_mem_read | i_mem_write);
    // Write wins when both strobes are set
    assign w_go_store = w_accept & i_mem_write & ~w_fault;
    assign w_go_load  = w_accept & ~i_mem_write & ~w_fault;

    // Upper address bits wrap silently; opcode family bits are not decoded
    assign w_unused_bits = ^{i_op_code[NB_OPCODE-1:3], i_alu_result[NB-1:NB_ADDR+2]};

    // Replicate the store operand across every lane so the byte enables
    // alone choose where it lands.
    always_comb begin
        case (w_size)
            c_size_byte: w_wdata = {(NB/8){i_store_data[7:0]}};
            c_size_half: w_wdata = {(NB/16){i_store_data[15:0]}};
            default:     w_wdata = i_store_data;
        endcase
    end

    mem_access_unit_load_extend #(
        .NB (NB)
    ) u_load_extend (
        .i_rdata    (i_mem_rdata),
        .i_addr_lo  (r_addr_lo),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_ext)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= c_st_idle;
            r_mem_addr   <= '0;
            r_mem_we     <= 4'b0000;
            r_mem_re     <= 1'b0;
            r_mem_wdata  <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_size       <= c_size_byte;
            r_unsigned   <= 1'b0;
        end else begin
            // Strobes and pulses are single-cycle by default
            r_mem_we     <= w_go_store ? f_byte_enable(w_size, w_addr_lo) : 4'b0000;
            r_mem_re     <= w_go_load;
            r_fault      <= w_accept & w_fault;
            r_load_valid <= 1'b0;

            if (w_go_store || w_go_load) begin
                r_mem_addr <= i_alu_result[NB_ADDR+1:2];
            end
            if (w_go_store) begin
                r_mem_wdata <= w_wdata;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_go_load) begin
                        r_state    <= c_st_read;
                        r_addr_lo  <= w_addr_lo;
                        r_size     <= w_size;
                        r_unsigned <= i_op_code[2];
                    end
                end
                c_st_read: begin
                    // Memory samples the address this cycle; data arrives next
                    r_state <= c_st_capture;
                end
                c_st_capture: begin
                    r_state      <= c_st_idle;
                    r_load_data  <= w_ext;
                    r_load_valid <= 1'b1;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign o_mem_addr   = r_mem_addr;
    assign o_mem_we     = r_mem_we;
    assign o_mem_re     = r_mem_re;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_load_data  = r_load_data;
    assign o_load_valid = r_load_valid;
    assign o_fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a
//               scoreboard of expected writes, loads and faults and a
//               one-cycle-latency data memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [5:0]  i_op_code;
    logic [31:0] i_alu_result;
    logic [31:0] i_store_data;
    logic [9:0]  o_mem_addr;
    logic [3:0]  o_mem_we;
    logic        o_mem_re;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_load_data;
    logic        o_load_valid;
    logic        o_fault;
    logic        o_stall;

    always #5 clk = ~clk;

    mem_access_unit #(
        .NB        (32),
        .NB_OPCODE (6),
        .NB_ADDR   (10)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_op_code    (i_op_code),
        .i_alu_result (i_alu_result),
        .i_store_data (i_store_data),
        .o_mem_addr   (o_mem_addr),
        .o_mem_we     (o_mem_we),
        .o_mem_re     (o_mem_re),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .o_load_data  (o_load_data),
        .o_load_valid (o_load_valid),
        .o_fault      (o_fault),
        .o_stall      (o_stall)
    );

    // One-cycle read latency memory (contents fixed for the load tests)
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (o_mem_re) i_mem_rdata <= mem[o_mem_addr];
    end

    typedef struct packed {
        logic [9:0]  addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_ld[$];
    bit          exp_flt[$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: anything the DUT emits must have been predicted
    task automatic monitor();
        wr_t w;
        if (o_mem_we !== 4'b0000) begin
            if (exp_wr.size() == 0) chk("unexpected_write", {28'd0, o_mem_we}, 32'd0);
            else begin
                w = exp_wr.pop_front();
                chk("wr_addr",  {22'd0, o_mem_addr}, {22'd0, w.addr});
                chk("wr_we",    {28'd0, o_mem_we},   {28'd0, w.we});
                chk("wr_wdata", o_mem_wdata,         w.wdata);
            end
        end
        if (o_load_valid !== 1'b0) begin
            if (exp_ld.size() == 0) chk("unexpected_load_valid", {31'd0, o_load_valid}, 32'd0);
            else chk("load_data", o_load_data, exp_ld.pop_front());
        end
        if (o_fault !== 1'b0) begin
            if (exp_flt.size() == 0) chk("unexpected_fault", {31'd0, o_fault}, 32'd0);
            else void'(exp_flt.pop_front());
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [5:0] op,
                         input logic [31:0] addr, input logic [31:0] data);
        i_valid      = 1'b1;
        i_mem_read   = rd;
        i_mem_write  = wr;
        i_op_code    = op;
        i_alu_result = addr;
        i_store_data = data;
    endtask

    task automatic idle_in();
        i_valid     = 1'b0;
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
    endtask

    task automatic do_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] we, input logic [31:0] wdata);
        exp_wr.push_back(wr_t'{addr: addr[11:2], we: we, wdata: wdata});
        drive(1'b0, 1'b1, op, addr, data);
        tick();
        chk("store_ready", {31'd0, o_ready}, 32'd1);
    endtask

    task automatic do_load(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] exp);
        exp_ld.push_back(exp);
        drive(1'b1, 1'b0, op, addr, 32'd0);
        tick();                                       // N+1
        idle_in();
        chk("load_re",    {31'd0, o_mem_re},   32'd1);
        chk("load_addr",  {22'd0, o_mem_addr}, {22'd0, addr[11:2]});
        chk("load_busy",  {31'd0, o_ready},    32'd0);
        tick();                                       // N+2
        chk("load_early", {31'd0, o_load_valid}, 32'd0);
        tick();                                       // N+3
        chk("load_valid", {31'd0, o_load_valid}, 32'd1);
        chk("load_ready", {31'd0, o_ready},      32'd1);
    endtask

    task automatic do_fault(input logic rd, input logic wr, input logic [5:0] op,
                            input logic [31:0] addr);
        exp_flt.push_back(1'b1);
        drive(rd, wr, op, addr, 32'h5555_5555);
        tick();                                       // N+1
        idle_in();
        chk("fault_pulse", {31'd0, o_fault},  32'd1);
        chk("fault_no_we", {28'd0, o_mem_we}, 32'd0);
        chk("fault_no_re", {31'd0, o_mem_re}, 32'd0);
        chk("fault_ready", {31'd0, o_ready},  32'd1);
        repeat (3) tick();
        chk("fault_cleared", {31'd0, o_fault}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[0] = 32'h1122_3344;
        mem[1] = 32'h8081_F0F7;
        i_mem_rdata  = 32'd0;
        i_reset      = 1'b0;
        i_op_code    = 6'd0;
        i_alu_result = 32'd0;
        i_store_data = 32'd0;
        idle_in();
        tick();
        tick();

        // Reset state
        chk("rst_ready",   {31'd0, o_ready},      32'd1);
        chk("rst_we",      {28'd0, o_mem_we},     32'd0);
        chk("rst_re",      {31'd0, o_mem_re},     32'd0);
        chk("rst_lvalid",  {31'd0, o_load_valid}, 32'd0);
        chk("rst_fault",   {31'd0, o_fault},      32'd0);
        chk("rst_addr",    {22'd0, o_mem_addr},   32'd0);
        chk("rst_wdata",   o_mem_wdata,           32'd0);
        chk("rst_ldata",   o_load_data,           32'd0);
        chk("rst_stall",   {31'd0, o_stall},      32'd0);
        i_reset = 1'b1;
        tick();

        // Back-to-back stores, one per cycle
        do_store(c_op_sw, 32'h0000_0008, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        do_store(c_op_sb, 32'h0000_0005, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        do_store(c_op_sh, 32'h0000_0006, 32'h0000_1234, 4'b1100, 32'h1234_1234);
        do_store(c_op_sb, 32'h0000_0003, 32'h0000_0077, 4'b1000, 32'h7777_7777);
        do_store(c_op_sh, 32'h0000_0000, 32'hABCD_5678, 4'b0011, 32'h5678_5678);
        // Upper address bits are dropped
        do_store(c_op_sw, 32'hFFFF_F00C, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);
        idle_in();
        tick();
        chk("store_one_cycle", {28'd0, o_mem_we}, 32'd0);

        // Loads from word 0x8081_F0F7 at byte address 0x4
        do_load(c_op_lb,  32'h0000_0007, 32'hFFFF_FF80);
        do_load(c_op_lbu, 32'h0000_0007, 32'h0000_0080);
        do_load(c_op_lh,  32'h0000_0004, 32'hFFFF_F0F7);
        do_load(c_op_lhu, 32'h0000_0006, 32'h0000_8081);
        do_load(c_op_lw,  32'h0000_0004, 32'h8081_F0F7);
        do_load(c_op_lb,  32'h0000_0004, 32'hFFFF_FFF7);
        do_load(c_op_lbu, 32'h0000_0005, 32'h0000_00F0);
        do_load(c_op_lh,  32'h0000_0000, 32'h0000_3344);
        do_load(c_op_lw,  32'h0000_0000, 32'h1122_3344);

        // Load result holds across a store
        do_store(c_op_sb, 32'h0000_0010, 32'h0000_0001, 4'b0001, 32'h0101_0101);
        idle_in();
        tick();
        chk("load_data_hold", o_load_data, 32'h1122_3344);

        // Stall with i_valid held: second request accepted in N+3
        exp_ld.push_back(32'h8081_F0F7);
        exp_ld.push_back(32'h8081_F0F7);
        drive(1'b1, 1'b0, c_op_lw, 32'h0000_0004, 32'd0);
        tick();                                       // N+1
        chk("stall_n1",  {31'd0, o_stall}, 32'd1);
        chk("ready_n1",  {31'd0, o_ready}, 32'd0);
        tick();                                       // N+2
        chk("stall_n2",  {31'd0, o_stall}, 32'd1);
        chk("ready_n2",  {31'd0, o_ready}, 32'd0);
        tick();                                       // N+3
        chk("ready_n3",  {31'd0, o_ready},      32'd1);
        chk("stall_n3",  {31'd0, o_stall},      32'd0);
        chk("lvalid_n3", {31'd0, o_load_valid}, 32'd1);
        tick();                                       // N+4
        chk("second_accept_re", {31'd0, o_mem_re}, 32'd1);
        idle_in();
        tick();
        tick();
        chk("second_lvalid", {31'd0, o_load_valid}, 32'd1);

        // Faults
        do_fault(1'b1, 1'b0, c_op_lw, 32'h0000_0002);
        do_fault(1'b0, 1'b1, c_op_sh, 32'h0000_0003);
        do_fault(1'b1, 1'b0, 6'b100010, 32'h0000_0000);

        // Reset during READ, with a request held through reset
        drive(1'b1, 1'b0, c_op_lw, 32'h0000_0004, 32'd0);
        tick();
        chk("pre_reset_re", {31'd0, o_mem_re}, 32'd1);
        #2 i_reset = 1'b0;
        #1;
        chk("arst_re",     {31'd0, o_mem_re},   32'd0);
        chk("arst_ready",  {31'd0, o_ready},    32'd1);
        chk("arst_addr",   {22'd0, o_mem_addr}, 32'd0);
        chk("arst_wdata",  o_mem_wdata,         32'd0);
        chk("arst_ldata",  o_load_data,         32'd0);
        tick();
        tick();
        chk("in_reset_re", {31'd0, o_mem_re}, 32'd0);
        i_reset = 1'b1;
        idle_in();
        repeat (4) tick();
        chk("post_reset_ready",  {31'd0, o_ready},      32'd1);
        chk("post_reset_lvalid", {31'd0, o_load_valid}, 32'd0);
        chk("post_reset_ldata",  o_load_data,           32'd0);

        // Everything predicted was produced
        chk("wr_queue_empty",    exp_wr.size(),  32'd0);
        chk("ld_queue_empty",    exp_ld.size(),  32'd0);
        chk("fault_queue_empty", exp_flt.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage consumer of the execute-stage result: takes the ALU result as a byte address plus the store operand, and drives the synchronous single-port data memory.
- Generates byte enables and lane-replicated write data for SB/SH/SW.
- Extracts and sign/zero-extends LB/LBU/LH/LHU/LW data from the returned word.
- Handshakes with the pipeline (valid/ready, stall) and flags misaligned or unsupported accesses.

Parameters:
- NB, 32, datapath width (bits).
- NB_OPCODE, 6, instruction opcode width.
- NB_ADDR, 10, data memory word-address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset; asynchronous, active-low.
- i_valid  in  1  execute-stage request valid.
- o_ready  out  1  unit can accept a request this cycle.
- i_mem_read  in  1  load request.
- i_mem_write  in  1  store request; priority over i_mem_read.
- i_op_code  in  NB_OPCODE  MIPS load/store opcode.
- i_alu_result  in  NB  effective byte address.
- i_store_data  in  NB  store operand (rt).
- o_mem_addr  out  NB_ADDR  word address = alu_result[NB_ADDR+1:2].
- o_mem_we  out  4  byte write enables, bit k = byte lane k (little-endian).
- o_mem_re  out  1  read strobe.
- o_mem_wdata  out  NB  lane-replicated write data.
- i_mem_rdata  in  NB  read word; valid the cycle after o_mem_re.
- o_load_data  out  NB  extended load result.
- o_load_valid  out  1  one-cycle pulse, o_load_data valid.
- o_fault  out  1  one-cycle pulse, misaligned or unsupported access.
- o_stall  out  1  i_valid & ~o_ready.

Behaviour:
- Accept: i_valid & o_ready & (i_mem_read | i_mem_write). No other condition starts a transaction.
- Opcode decode:
  - size = op_code[1:0]: 00 byte, 01 half, 11 word, 10 unsupported.
  - op_code[2] = 1 selects zero-extend (loads only).
- Fault conditions: size 10; half access with addr[0] ≠ 0; word access with addr[1:0] ≠ 0.
  - A faulting request is accepted and consumes one cycle.
  - No memory strobe, no o_load_valid.
  - o_fault = 1 in cycle N+1.
- All memory-side outputs are registered. Nothing is driven combinationally from the inputs.
- FSM states: IDLE, READ, CAPTURE. o_ready = 1 only in IDLE.
- Store accepted in cycle N (IDLE stays IDLE):
  - o_mem_we, o_mem_addr, o_mem_wdata valid in N+1 only.
  - Back-to-back stores: one per cycle.
  - SB: wdata = {4{data[7:0]}}, we = 0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}, we = 0011 if addr[1] = 0, else 1100.
  - SW: wdata = data, we = 1111.
- Load accepted in cycle N:
  - IDLE→READ. In N+1: o_mem_re = 1, o_mem_addr valid.
  - READ→CAPTURE. In N+2: i_mem_rdata is sampled, extracted, and registered.
  - CAPTURE→IDLE. In N+3: o_load_valid = 1, o_load_data valid.
  - Load latency is 3 cycles. A new request can be accepted in N+3.
- Extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Signed ops replicate the MSB of the selected field; unsigned ops zero-fill.
- Registered request fields (addr, size, sign) are held from accept until CAPTURE completes.
- o_load_data holds its last value until the next load completes.
- Address bits above NB_ADDR+1 are ignored; no wrap fault.
- Reset values (asserted asynchronously):
  - State IDLE; o_mem_we = 0, o_mem_re = 0, o_load_valid = 0, o_fault = 0.
  - o_mem_addr = 0, o_mem_wdata = 0, o_load_data = 0.
- Reset mid-load aborts the transaction. No o_load_valid is produced after release.
- Requests while reset is low are dropped.

Decomposition:
- Shared header holds:
  - opcode constants: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011.
  - size codes.
  - FSM state encodings.
- One combinational sub-module, load_extend: (rdata, addr[1:0], size, unsigned) → extended word. It is reusable by a future cache path.

Test Plan:
- SW addr 0x0000_0008, data 0xDEAD_BEEF → N+1: o_mem_addr = 2, o_mem_we = 1111, o_mem_wdata = 0xDEADBEEF. o_ready stays 1.
- SB addr 0x0000_0005, data 0x0000_00A5 → o_mem_we = 0010, o_mem_wdata = 0xA5A5A5A5. Repeat with SH addr 0x6, data 0x1234 → we = 1100, wdata = 0x12341234.
- Memory returns word 0x8081_F0F7 for address 0x4 with a one-cycle read model:
  - LB addr 0x7 → o_load_data 0xFFFF_FF80 at N+3.
  - LBU addr 0x7 → 0x0000_0080.
  - LH addr 0x4 → 0xFFFF_F0F7.
  - LHU addr 0x6 → 0x0000_8081.
  - LW → 0x8081_F0F7.
- Load accepted, i_valid held high → o_ready = 0 and o_stall = 1 in N+1 and N+2; next request accepted in N+3.
- LW addr 0x2, then SH addr 0x3, then opcode 100010 → o_fault pulse each time, no o_mem_we/o_mem_re, no o_load_valid.
- i_reset low during READ → all outputs 0 immediately. After release: state IDLE, o_ready = 1, no spurious o_load_valid.
